// File: rtl/aibnd_dll_ctrl_if.sv
// rtl/aibnd_dll_ctrl_if.sv - delay-line and phase-detector signal bundle for the AIB DLL lock controller
`timescale 1ns/1ps
interface aibnd_dll_ctrl_if;
    logic       launch;
    logic       measure;
    logic       t_up;
    logic       t_down;
    logic [2:0] i_gray;
    logic [6:0] f_gray;
    logic [9:0] pvt_ref_half_gry;

    modport master (
        output launch, measure, i_gray, f_gray, pvt_ref_half_gry,
        input  t_up, t_down
    );

    modport slave (
        input  launch, measure, i_gray, f_gray, pvt_ref_half_gry,
        output t_up, t_down
    );
endinterface

// File: rtl/aibnd_dll_ctrl.sv
// rtl/aibnd_dll_ctrl.sv - AIB DLL/DCC lock controller: launch/measure sequencing and binary delay-code search
`timescale 1ns/1ps
module aibnd_dll_ctrl #(
    parameter int SETTLE_CYC = 4,
    parameter int PD_CYC     = 4,
    parameter int STEP_INIT  = 64,
    parameter int LOCK_REV   = 4,
    parameter int MAX_ITER   = 2047,
    parameter int INIT_CODE  = 512
) (
    input  logic             clk_dcd,
    input  logic             dll_reset,
    input  logic             dll_en,
    input  logic             rb_cont_cal,
    aibnd_dll_ctrl_if.master dl,
    output logic             dll_lock,
    output logic             dll_err,
    output logic [9:0]       code_bin
);
    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_SETTLE, S_MEAS, S_PDWAIT, S_EVAL, S_LOCKED, S_ERR
    } state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t      state, state_nxt;
    dir_t        last_dir, last_dir_nxt;
    logic [9:0]  step, step_nxt, code_nxt, mv;
    logic [10:0] sum;
    logic [7:0]  rev_cnt, rev_nxt;
    logic [11:0] iter;
    logic [15:0] cnt;
    logic [1:0]  up_sync, dn_sync;
    logic        dir_up, dir_dn, reversal, lock_hit;

    function automatic logic [9:0] split_gray(input logic [9:0] b);
        return {b[9:7] ^ {1'b0, b[9:8]}, b[6:0] ^ {1'b0, b[6:1]}};
    endfunction

    function automatic logic [9:0] half_gray(input logic [9:0] b);
        logic [9:0] h;
        h = {1'b0, b[9:1]};
        return {h[6:0] ^ {1'b0, h[6:1]}, h[9:7] ^ {1'b0, h[9:8]}};
    endfunction

    // PD outputs are asynchronous to clk_dcd
    always_ff @(posedge clk_dcd) begin
        if (dll_reset) begin
            up_sync <= 2'b00;
            dn_sync <= 2'b00;
        end else begin
            up_sync <= {up_sync[0], dl.t_up};
            dn_sync <= {dn_sync[0], dl.t_down};
        end
    end

    always_ff @(posedge clk_dcd) begin
        if (dll_reset) state <= S_IDLE;
        else           state <= state_nxt;
    end

    // Search decision; only committed in EVAL. Once locked the search degenerates to +/-1 tracking.
    always_comb begin
        dir_up       = up_sync[1] & ~dn_sync[1];
        dir_dn       = dn_sync[1] & ~up_sync[1];
        reversal     = (dir_up && last_dir == DIR_DN) || (dir_dn && last_dir == DIR_UP);
        step_nxt     = step;
        rev_nxt      = rev_cnt;
        last_dir_nxt = last_dir;
        code_nxt     = code_bin;
        if (reversal && !dll_lock) begin
            step_nxt = (step > 10'd1) ? (step >> 1) : 10'd1;
            if (step_nxt == 10'd1) rev_nxt = rev_cnt + 8'd1;
        end
        mv  = dll_lock ? 10'd1 : step_nxt;
        sum = {1'b0, code_bin} + {1'b0, mv};
        if (dir_up) begin
            code_nxt     = sum[10] ? 10'h3ff : sum[9:0];
            last_dir_nxt = DIR_UP;
        end else if (dir_dn) begin
            code_nxt     = (code_bin < mv) ? 10'd0 : (code_bin - mv);
            last_dir_nxt = DIR_DN;
        end
        lock_hit = !dll_lock && (rev_nxt >= 8'(LOCK_REV));
    end

    always_comb begin
        state_nxt = state;
        if (!dll_en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   state_nxt = S_LAUNCH;
                S_LAUNCH: state_nxt = S_SETTLE;
                S_SETTLE: if (cnt == 16'd0) state_nxt = S_MEAS;
                S_MEAS:   state_nxt = S_PDWAIT;
                S_PDWAIT: if (cnt == 16'd0) state_nxt = S_EVAL;
                S_EVAL: begin
                    if (dll_lock || lock_hit)            state_nxt = S_LOCKED;
                    else if (iter == 12'(MAX_ITER - 1))  state_nxt = S_ERR;
                    else                                 state_nxt = S_LAUNCH;
                end
                S_LOCKED: if (rb_cont_cal) state_nxt = S_LAUNCH;
                S_ERR:    state_nxt = S_ERR;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dl.launch  = (state == S_LAUNCH);
        dl.measure = (state == S_MEAS);
        dll_err    = (state == S_ERR);
    end

    // Dropping dll_en keeps the code so a re-enable resumes from the last position.
    always_ff @(posedge clk_dcd) begin
        if (dll_reset) begin
            code_bin               <= 10'(INIT_CODE);
            {dl.i_gray, dl.f_gray} <= split_gray(10'(INIT_CODE));
            dl.pvt_ref_half_gry    <= 10'd0;
            step                   <= 10'(STEP_INIT);
            rev_cnt                <= 8'd0;
            iter                   <= 12'd0;
            last_dir               <= DIR_NONE;
            cnt                    <= 16'd0;
            dll_lock               <= 1'b0;
        end else if (!dll_en) begin
            step     <= 10'(STEP_INIT);
            rev_cnt  <= 8'd0;
            iter     <= 12'd0;
            last_dir <= DIR_NONE;
            dll_lock <= 1'b0;
        end else begin
            case (state)
                S_LAUNCH: cnt <= 16'(SETTLE_CYC - 1);
                S_MEAS:   cnt <= 16'(PD_CYC - 1);
                S_SETTLE, S_PDWAIT: if (cnt != 16'd0) cnt <= cnt - 16'd1;
                S_EVAL: begin
                    code_bin               <= code_nxt;
                    {dl.i_gray, dl.f_gray} <= split_gray(code_nxt);
                    step                   <= step_nxt;
                    rev_cnt                <= rev_nxt;
                    last_dir               <= last_dir_nxt;
                    if (!dll_lock) iter <= iter + 12'd1;
                    if (dll_lock || lock_hit) begin
                        dll_lock            <= 1'b1;
                        dl.pvt_ref_half_gry <= half_gray(code_nxt);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aibnd_dll_ctrl.sv
// tb/tb_aibnd_dll_ctrl.sv - self-checking bench for aibnd_dll_ctrl against a behavioural search model
`timescale 1ns/1ps
module tb_aibnd_dll_ctrl;
    localparam int PD_CYC   = 4;
    localparam int MAX_ITER = 2047;

    logic       clk_dcd = 1'b0;
    logic       dll_reset, dll_en, rb_cont_cal;
    logic       dll_lock, dll_err;
    logic [9:0] code_bin;

    int n_chk  = 0;
    int n_pass = 0;
    int m_code, m_step, m_rev, m_last, m_iter;
    bit m_lock;
    bit prev_launch = 1'b0, prev_measure = 1'b0;

    aibnd_dll_ctrl_if dl ();

    aibnd_dll_ctrl dut (
        .clk_dcd    (clk_dcd),
        .dll_reset  (dll_reset),
        .dll_en     (dll_en),
        .rb_cont_cal(rb_cont_cal),
        .dl         (dl),
        .dll_lock   (dll_lock),
        .dll_err    (dll_err),
        .code_bin   (code_bin)
    );

    always #5 clk_dcd = ~clk_dcd;

    always @(negedge clk_dcd) begin
        if (dll_reset === 1'b0) begin
            n_chk++;
            if ((dl.launch && dl.measure) || (dl.launch && prev_launch) || (dl.measure && prev_measure))
                $display("FAIL pulse_shape: launch=%0b measure=%0b prev_launch=%0b prev_measure=%0b, required single-cycle non-overlapping pulses",
                         dl.launch, dl.measure, prev_launch, prev_measure);
            else
                n_pass++;
        end
        prev_launch  = dl.launch;
        prev_measure = dl.measure;
    end

    function automatic int clamp10(input int v);
        return (v < 0) ? 0 : ((v > 1023) ? 1023 : v);
    endfunction

    function automatic logic [9:0] exp_gray(input int c);
        int hi, lo;
        hi = c / 128;
        lo = c % 128;
        return {3'(hi ^ (hi >> 1)), 7'(lo ^ (lo >> 1))};
    endfunction

    function automatic logic [9:0] exp_half(input int c);
        int hi, lo;
        hi = (c / 2) / 128;
        lo = (c / 2) % 128;
        return {7'(lo ^ (lo >> 1)), 3'(hi ^ (hi >> 1))};
    endfunction

    task automatic model_restart();
        m_step = 64; m_rev = 0; m_last = 0; m_iter = 0; m_lock = 1'b0;
    endtask

    task automatic model_eval(input bit up, input bit dn);
        int dir;
        dir = (up && !dn) ? 1 : ((dn && !up) ? -1 : 0);
        if (!m_lock) m_iter++;
        if (dir == 0) return;
        if (m_lock) begin
            m_code = clamp10(m_code + dir);
            m_last = dir;
            return;
        end
        if (m_last != 0 && dir != m_last) begin
            m_step = (m_step > 1) ? m_step / 2 : 1;
            if (m_step == 1) m_rev++;
        end
        m_code = clamp10(m_code + dir * m_step);
        m_last = dir;
        if (m_rev >= 4) m_lock = 1'b1;
    endtask

    task automatic do_reset();
        dll_reset = 1'b1; dll_en = 1'b0; rb_cont_cal = 1'b0;
        dl.t_up = 1'b0; dl.t_down = 1'b0;
        repeat (2) @(negedge clk_dcd);
        dll_reset = 1'b0;
        m_code = 512;
        model_restart();
    endtask

    // One search iteration: hold the PD inputs, find the measure pulse, sample once the EVAL result is visible.
    task automatic run_iter(input bit up, input bit dn, output bit ok);
        ok = 1'b0;
        dl.t_up = up; dl.t_down = dn;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_dcd);
            if (dl.measure === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++;
        if (!ok) $display("FAIL measure_timeout: no measure pulse within 40 cycles, required one");
        else begin
            n_pass++;
            repeat (PD_CYC + 2) @(negedge clk_dcd);
        end
    endtask

    task automatic test_reset();
        do_reset();
        dll_reset = 1'b1;
        @(negedge clk_dcd);
        n_chk++; if (code_bin !== 10'd512) $display("FAIL reset_code: got %0d required 512", code_bin); else n_pass++;
        n_chk++; if ({dl.i_gray, dl.f_gray} !== {3'b110, 7'd0}) $display("FAIL reset_gray: got %b required 1100000000", {dl.i_gray, dl.f_gray}); else n_pass++;
        n_chk++; if ({dll_lock, dll_err, dl.launch, dl.measure} !== 4'b0) $display("FAIL reset_flags: got %b required 0000", {dll_lock, dll_err, dl.launch, dl.measure}); else n_pass++;
        n_chk++; if (dl.pvt_ref_half_gry !== 10'd0) $display("FAIL reset_pvt: got %0d required 0", dl.pvt_ref_half_gry); else n_pass++;
        dll_reset = 1'b0;
    endtask

    task automatic test_reset_mid_pdwait();
        bit ok, up;
        do_reset();
        dll_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            up = 1'($urandom_range(1));
            run_iter(up, !up, ok);
            if (!ok) return;
            model_eval(up, !up);
            n_chk++; if (code_bin !== 10'(m_code)) $display("FAIL pre_reset_code: got %0d required %0d", code_bin, m_code); else n_pass++;
        end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_dcd);
            if (dl.measure === 1'b1) begin ok = 1'b1; break; end
        end
        repeat (2) @(negedge clk_dcd);
        dll_reset = 1'b1;
        @(negedge clk_dcd);
        n_chk++; if (code_bin !== 10'd512) $display("FAIL midreset_code: got %0d required 512", code_bin); else n_pass++;
        n_chk++; if ({dl.i_gray, dl.f_gray} !== {3'b110, 7'd0}) $display("FAIL midreset_gray: got %b required 1100000000", {dl.i_gray, dl.f_gray}); else n_pass++;
        n_chk++; if ({dll_lock, dll_err, dl.launch, dl.measure} !== 4'b0) $display("FAIL midreset_flags: got %b required 0000", {dll_lock, dll_err, dl.launch, dl.measure}); else n_pass++;
        dll_reset = 1'b0;
        dll_en = 1'b0;
    endtask

    task automatic test_hold_then_up();
        bit ok;
        do_reset();
        dll_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            run_iter(1'b1, 1'b1, ok);
            if (!ok) return;
            model_eval(1'b1, 1'b1);
            n_chk++; if (code_bin !== 10'd512) $display("FAIL hold_code: iter %0d got %0d required 512", i, code_bin); else n_pass++;
        end
        run_iter(1'b1, 1'b0, ok);
        if (!ok) return;
        model_eval(1'b1, 1'b0);
        n_chk++; if (code_bin !== 10'd576) $display("FAIL hold_then_up: got %0d required 576", code_bin); else n_pass++;
        n_chk++; if ({dl.i_gray, dl.f_gray} !== exp_gray(576)) $display("FAIL hold_then_up_gray: got %b required %b", {dl.i_gray, dl.f_gray}, exp_gray(576)); else n_pass++;
    endtask

    task automatic test_threshold_lock();
        int seq [18] = '{448, 384, 320, 256, 288, 320, 304, 288, 296, 304, 300, 296, 298, 300, 299, 300, 299, 300};
        bit ok, up;
        do_reset();
        dll_en = 1'b1;
        for (int i = 0; i < 18; i++) begin
            up = (m_code < 300);
            run_iter(up, !up, ok);
            if (!ok) return;
            model_eval(up, !up);
            n_chk++; if (code_bin !== 10'(seq[i])) $display("FAIL thr_code: eval %0d got %0d required %0d", i + 1, code_bin, seq[i]); else n_pass++;
            n_chk++; if ({dl.i_gray, dl.f_gray} !== exp_gray(seq[i])) $display("FAIL thr_gray: eval %0d got %b required %b", i + 1, {dl.i_gray, dl.f_gray}, exp_gray(seq[i])); else n_pass++;
            n_chk++; if (dll_lock !== (i == 17)) $display("FAIL thr_lock: eval %0d got %0b required %0b", i + 1, dll_lock, (i == 17)); else n_pass++;
        end
        n_chk++; if (dl.pvt_ref_half_gry !== 10'b0011101001) $display("FAIL thr_pvt: got %b required 0011101001", dl.pvt_ref_half_gry); else n_pass++;
    endtask

    task automatic test_tracking();
        bit ok, up;
        rb_cont_cal = 1'b1;
        for (int i = 0; i < 12; i++) begin
            up = (m_code < 310);
            run_iter(up, !up, ok);
            if (!ok) return;
            model_eval(up, !up);
            n_chk++; if (code_bin !== 10'(m_code)) $display("FAIL track_code: iter %0d got %0d required %0d", i, code_bin, m_code); else n_pass++;
            n_chk++; if (dll_lock !== 1'b1) $display("FAIL track_lock: iter %0d got %0b required 1", i, dll_lock); else n_pass++;
            n_chk++; if (dl.pvt_ref_half_gry !== exp_half(m_code)) $display("FAIL track_pvt: iter %0d got %b required %b", i, dl.pvt_ref_half_gry, exp_half(m_code)); else n_pass++;
        end
        n_chk++; if (code_bin !== 10'd310) $display("FAIL track_final: got %0d required 310", code_bin); else n_pass++;
        n_chk++; if (dl.pvt_ref_half_gry !== exp_half(310)) $display("FAIL track_pvt155: got %b required %b", dl.pvt_ref_half_gry, exp_half(310)); else n_pass++;
    endtask

    task automatic test_disable();
        bit ok, seen_meas;
        logic [9:0] held;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_dcd);
            if (dl.launch === 1'b1) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok) $display("FAIL launch_timeout: no launch within 40 cycles, required one"); else n_pass++;
        @(negedge clk_dcd);
        dll_en = 1'b0;
        held = code_bin;
        seen_meas = 1'b0;
        @(negedge clk_dcd);
        n_chk++; if (dll_lock !== 1'b0) $display("FAIL dis_lock: got %0b required 0", dll_lock); else n_pass++;
        for (int k = 0; k < 15; k++) begin
            if (dl.measure === 1'b1) seen_meas = 1'b1;
            @(negedge clk_dcd);
        end
        n_chk++; if (seen_meas !== 1'b0) $display("FAIL dis_measure: got pulse %0b required 0", seen_meas); else n_pass++;
        n_chk++; if (code_bin !== held) $display("FAIL dis_code: got %0d required %0d", code_bin, held); else n_pass++;
        rb_cont_cal = 1'b0;
        dll_en = 1'b1;
        @(negedge clk_dcd);
        n_chk++; if (dl.launch !== 1'b1) $display("FAIL reen_launch: got %0b required 1", dl.launch); else n_pass++;
        m_code = int'(held);
        model_restart();
        run_iter(1'b0, 1'b1, ok);
        if (!ok) return;
        model_eval(1'b0, 1'b1);
        n_chk++; if (code_bin !== 10'(m_code)) $display("FAIL reen_step: got %0d required %0d", code_bin, m_code); else n_pass++;
    endtask

    task automatic test_random_lock();
        bit ok, up, dn;
        int thr, r;
        for (int t = 0; t < 4; t++) begin
            do_reset();
            dll_en = 1'b1;
            thr = int'($urandom_range(900, 100));
            for (int i = 0; i < 80; i++) begin
                up = (m_code < thr);
                dn = !up;
                r = int'($urandom_range(7));
                if (r == 0) begin up = 1'b1; dn = 1'b1; end
                if (r == 1) begin up = 1'b0; dn = 1'b0; end
                run_iter(up, dn, ok);
                if (!ok) return;
                model_eval(up, dn);
                n_chk++; if (code_bin !== 10'(m_code)) $display("FAIL rnd_code: thr %0d eval %0d got %0d required %0d", thr, i, code_bin, m_code); else n_pass++;
                n_chk++; if ({dl.i_gray, dl.f_gray} !== exp_gray(m_code)) $display("FAIL rnd_gray: thr %0d got %b required %b", thr, {dl.i_gray, dl.f_gray}, exp_gray(m_code)); else n_pass++;
                n_chk++; if (dll_lock !== m_lock) $display("FAIL rnd_lock: thr %0d eval %0d got %0b required %0b", thr, i, dll_lock, m_lock); else n_pass++;
                if (m_lock) begin
                    n_chk++; if (dl.pvt_ref_half_gry !== exp_half(m_code)) $display("FAIL rnd_pvt: got %b required %b", dl.pvt_ref_half_gry, exp_half(m_code)); else n_pass++;
                    break;
                end
            end
        end
    endtask

    task automatic test_stuck_up();
        bit ok;
        int launches;
        do_reset();
        dll_en = 1'b1;
        for (int i = 0; i < MAX_ITER; i++) begin
            run_iter(1'b1, 1'b0, ok);
            if (!ok) return;
            model_eval(1'b1, 1'b0);
            n_chk++; if (code_bin !== 10'(m_code)) $display("FAIL stuck_code: eval %0d got %0d required %0d", i + 1, code_bin, m_code); else n_pass++;
            n_chk++; if (dll_err !== (m_iter >= MAX_ITER)) $display("FAIL stuck_err: eval %0d got %0b required %0b", i + 1, dll_err, (m_iter >= MAX_ITER)); else n_pass++;
        end
        n_chk++; if (code_bin !== 10'd1023) $display("FAIL stuck_rail: got %0d required 1023", code_bin); else n_pass++;
        n_chk++; if (dll_lock !== 1'b0) $display("FAIL stuck_lock: got %0b required 0", dll_lock); else n_pass++;
        launches = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk_dcd);
            if (dl.launch === 1'b1) launches++;
        end
        n_chk++; if (launches != 0) $display("FAIL stuck_launch: got %0d launches required 0", launches); else n_pass++;
        n_chk++; if (dll_err !== 1'b1) $display("FAIL stuck_err_hold: got %0b required 1", dll_err); else n_pass++;
    endtask

    initial begin
        dll_reset = 1'b1; dll_en = 1'b0; rb_cont_cal = 1'b0;
        dl.t_up = 1'b0; dl.t_down = 1'b0;
        test_reset();
        test_reset_mid_pdwait();
        test_hold_then_up();
        test_threshold_lock();
        test_tracking();
        test_disable();
        test_random_lock();
        test_stuck_up();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
